swacc_mtt_wr_splitter: RTL and testbench

// - Downstream consumer of the MR command demux's MTT output stream (CEU WR_MTT_TPT commands).
// - Unpacks 256-bit data beats into 64-bit MTT entries and issues one indexed entry-write per handshake toward the MTT cache/ICM write path.
// - Checks command type and entry count against beat count; reports completion and format errors as pulses.

---
 rtl/swacc_mtt_wr_splitter_pkg.sv | 43 ++++
 rtl/swacc_mtt_wr_splitter.sv | 119 +++++++++++
 tb/tb_swacc_mtt_wr_splitter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/swacc_mtt_wr_splitter_pkg.sv
// Shared definitions for the MTT write splitter: CEU command codes, head field
// offsets, entry/lane geometry and the splitter FSM state type.
package swacc_mtt_wr_splitter_pkg;

  localparam int HEAD_WIDTH  = 128;
  localparam int DATA_WIDTH  = 256;
  localparam int ENTRY_WIDTH = 64;
  localparam int LANES       = DATA_WIDTH / ENTRY_WIDTH;

  localparam int HEAD_TYPE_MSB  = 127;
  localparam int HEAD_TYPE_LSB  = 124;
  localparam int HEAD_COUNT_MSB = 79;
  localparam int HEAD_COUNT_LSB = 64;
  localparam int HEAD_INDEX_MSB = 63;
  localparam int HEAD_INDEX_LSB = 0;

  localparam logic [3:0] CMD_WR_MPT     = 4'h1;
  localparam logic [3:0] CMD_WR_MTT_TPT = 4'h2;
  localparam logic [3:0] CMD_DEREG_MR   = 4'h3;
  localparam logic [3:0] CMD_QUERY_MPT  = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FETCH = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  function automatic logic [ENTRY_WIDTH-1:0] lane_entry(
    input logic [DATA_WIDTH-1:0] data,
    input logic [1:0]            lane
  );
    logic [ENTRY_WIDTH-1:0] e;
    case (lane)
      2'd0:    e = data[0*ENTRY_WIDTH +: ENTRY_WIDTH];
      2'd1:    e = data[1*ENTRY_WIDTH +: ENTRY_WIDTH];
      2'd2:    e = data[2*ENTRY_WIDTH +: ENTRY_WIDTH];
      default: e = data[3*ENTRY_WIDTH +: ENTRY_WIDTH];
    endcase
    return e;
  endfunction

endpackage

// File: rtl/swacc_mtt_wr_splitter.sv
// Splits CEU WR_MTT_TPT command beats into one indexed 64-bit entry write per
// handshake, and flags completion or malformed commands with one-cycle pulses.
module swacc_mtt_wr_splitter
  import swacc_mtt_wr_splitter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mtt_req_valid,
  input  logic [HEAD_WIDTH-1:0]  mtt_req_head,
  input  logic                   mtt_req_last,
  input  logic [DATA_WIDTH-1:0]  mtt_req_data,
  output logic                   mtt_req_ready,
  output logic                   mtt_wr_valid,
  output logic [63:0]            mtt_wr_index,
  output logic [ENTRY_WIDTH-1:0] mtt_wr_entry,
  input  logic                   mtt_wr_ready,
  output logic                   cmd_done,
  output logic                   cmd_err
);

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   beat_data_q;
  logic                    beat_last_q;
  logic [1:0]              lane_q;
  logic [15:0]             remaining_q;
  logic [63:0]             cur_index_q;
  logic                    done_q;
  logic                    err_q;

  logic                    req_hs;
  logic                    head_ok;
  logic [15:0]             head_count;

  // Ready is gated by reset so every output reads 0 while rst is held low.
  assign mtt_req_ready = rst && (state_q != ST_ISSUE);
  assign mtt_wr_valid  = (state_q == ST_ISSUE);
  assign mtt_wr_index  = cur_index_q;
  assign mtt_wr_entry  = lane_entry(beat_data_q, lane_q);
  assign cmd_done      = done_q;
  assign cmd_err       = err_q;

  assign req_hs     = mtt_req_valid && mtt_req_ready;
  assign head_count = mtt_req_head[HEAD_COUNT_MSB:HEAD_COUNT_LSB];
  assign head_ok    = (mtt_req_head[HEAD_TYPE_MSB:HEAD_TYPE_LSB] == CMD_WR_MTT_TPT) &&
                      (head_count != 16'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      beat_data_q <= '0;
      beat_last_q <= 1'b0;
      lane_q      <= 2'd0;
      remaining_q <= 16'd0;
      cur_index_q <= 64'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_hs) begin
            beat_data_q <= mtt_req_data;
            beat_last_q <= mtt_req_last;
            lane_q      <= 2'd0;
            remaining_q <= head_count;
            cur_index_q <= mtt_req_head[HEAD_INDEX_MSB:HEAD_INDEX_LSB];
            if (head_ok) begin
              state_q <= ST_ISSUE;
            end else if (mtt_req_last) begin
              err_q <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_ISSUE: begin
          if (mtt_wr_ready) begin
            cur_index_q <= cur_index_q + 64'd1;
            remaining_q <= remaining_q - 16'd1;
            lane_q      <= lane_q + 2'd1;
            if (remaining_q == 16'd1) begin
              // Count satisfied; any further beats are excess and get drained.
              if (beat_last_q) begin
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                state_q <= ST_DRAIN;
              end
            end else if (lane_q == 2'd3) begin
              if (beat_last_q) begin
                err_q   <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                state_q <= ST_FETCH;
              end
            end
          end
        end
        ST_FETCH: begin
          if (req_hs) begin
            beat_data_q <= mtt_req_data;
            beat_last_q <= mtt_req_last;
            lane_q      <= 2'd0;
            state_q     <= ST_ISSUE;
          end
        end
        ST_DRAIN: begin
          if (req_hs && mtt_req_last) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swacc_mtt_wr_splitter.sv
// Randomized self-checking bench for swacc_mtt_wr_splitter against a
// command-level reference model of the expected entry writes and status pulse.
module tb_swacc_mtt_wr_splitter;
  import swacc_mtt_wr_splitter_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         mtt_req_valid = 1'b0;
  logic [127:0] mtt_req_head  = '0;
  logic         mtt_req_last  = 1'b0;
  logic [255:0] mtt_req_data  = '0;
  logic         mtt_req_ready;
  logic         mtt_wr_valid;
  logic [63:0]  mtt_wr_index;
  logic [63:0]  mtt_wr_entry;
  logic         mtt_wr_ready = 1'b1;
  logic         cmd_done;
  logic         cmd_err;

  swacc_mtt_wr_splitter dut (
    .clk(clk), .rst(rst),
    .mtt_req_valid(mtt_req_valid), .mtt_req_head(mtt_req_head),
    .mtt_req_last(mtt_req_last), .mtt_req_data(mtt_req_data),
    .mtt_req_ready(mtt_req_ready),
    .mtt_wr_valid(mtt_wr_valid), .mtt_wr_index(mtt_wr_index),
    .mtt_wr_entry(mtt_wr_entry), .mtt_wr_ready(mtt_wr_ready),
    .cmd_done(cmd_done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int stall_mode = 0;   // 0: always ready, 1: random stalls, 2: never ready

  logic [255:0] beats[$];
  logic [63:0]  exp_idx[$], exp_ent[$];
  bit           exp_done, exp_err;
  logic [63:0]  obs_idx[$], obs_ent[$];
  int           obs_cyc[$], req_hs_cyc[$];
  int           done_cnt, err_cnt;
  bit           pulse_ready;

  initial begin
    forever begin
      @(posedge clk); #1;
      case (stall_mode)
        0:       mtt_wr_ready = 1'b1;
        1:       mtt_wr_ready = ($urandom_range(0, 2) != 0);
        default: mtt_wr_ready = 1'b0;
      endcase
    end
  end

  // Monitor: everything sampled mid-cycle, where inputs and outputs are stable.
  bit          prev_stall = 0;
  logic [63:0] prev_idx, prev_ent;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (mtt_req_valid && mtt_req_ready) req_hs_cyc.push_back(cyc);
      if (mtt_wr_valid && mtt_wr_ready) begin
        obs_idx.push_back(mtt_wr_index);
        obs_ent.push_back(mtt_wr_entry);
        obs_cyc.push_back(cyc);
      end
      if (mtt_wr_valid) begin
        tests++;
        if (mtt_req_ready !== 1'b0) begin
          fails++;
          $display("FAIL ready_in_issue: ready=%b required 0 at cyc %0d", mtt_req_ready, cyc);
        end
      end
      if (prev_stall) begin
        tests++;
        if (mtt_wr_valid !== 1'b1 || mtt_wr_index !== prev_idx || mtt_wr_entry !== prev_ent) begin
          fails++;
          $display("FAIL stall_stable: valid=%b idx=%h ent=%h required 1 %h %h",
                   mtt_wr_valid, mtt_wr_index, mtt_wr_entry, prev_idx, prev_ent);
        end
      end
      prev_stall = mtt_wr_valid && !mtt_wr_ready;
      prev_idx   = mtt_wr_index;
      prev_ent   = mtt_wr_entry;
      if (cmd_done || cmd_err) begin
        pulse_ready = mtt_req_ready;
        tests++;
        if (cmd_done && cmd_err) begin
          fails++;
          $display("FAIL pulse_exclusive: done=%b err=%b required not both", cmd_done, cmd_err);
        end
      end
      if (cmd_done) done_cnt++;
      if (cmd_err)  err_cnt++;
    end else begin
      prev_stall = 0;
    end
  end

  // Reference: which entries a command writes and how it terminates.
  task automatic model(input logic [3:0] typ, input logic [15:0] cnt,
                       input logic [63:0] idx, input int nb);
    int n;
    logic [255:0] bd;
    exp_idx.delete(); exp_ent.delete();
    if (typ != CMD_WR_MTT_TPT || cnt == 0) begin
      exp_done = 0; exp_err = 1;
      return;
    end
    n = (int'(cnt) < 4 * nb) ? int'(cnt) : 4 * nb;
    for (int k = 0; k < n; k++) begin
      bd = beats[k / 4];
      exp_idx.push_back(idx + 64'(k));
      exp_ent.push_back(bd[64 * (k % 4) +: 64]);
    end
    exp_done = (int'(cnt) <= 4 * nb) && ((int'(cnt) + 3) / 4 == nb);
    exp_err  = !exp_done;
  endtask

  task automatic send_beats(input logic [127:0] head, input int nb, input bit gaps,
                            output bit ok);
    ok = 1;
    for (int b = 0; b < nb; b++) begin
      int budget;
      bit hs;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      mtt_req_valid = 1'b1;
      mtt_req_head  = (b == 0) ? head : {$urandom, $urandom, $urandom, $urandom};
      mtt_req_data  = beats[b];
      mtt_req_last  = (b == nb - 1);
      budget = 0; hs = 0;
      while (!hs) begin
        @(negedge clk); hs = mtt_req_ready;
        @(posedge clk); #1;
        budget++;
        if (budget > 1000) begin
          tests++; fails++;
          $display("FAIL beat_timeout: beat %0d not accepted within %0d cycles", b, budget);
          mtt_req_valid = 1'b0; ok = 0;
          return;
        end
      end
      mtt_req_valid = 1'b0;
    end
  endtask

  task automatic run_cmd(input string nm, input logic [3:0] typ, input logic [15:0] cnt,
                         input logic [63:0] idx, input int nb, input bit gaps);
    bit ok;
    int w;
    beats.delete();
    for (int b = 0; b < nb; b++)
      beats.push_back({$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom});
    model(typ, cnt, idx, nb);
    obs_idx.delete(); obs_ent.delete(); obs_cyc.delete(); req_hs_cyc.delete();
    done_cnt = 0; err_cnt = 0;
    send_beats({typ, 12'h0, $urandom, cnt, idx}, nb, gaps, ok);
    w = 0;
    while (done_cnt + err_cnt == 0 && w < 2000) begin @(negedge clk); w++; end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    tests++;
    if (done_cnt + err_cnt == 0) begin
      fails++;
      $display("FAIL %s pulse_timeout: no status pulse within %0d cycles", nm, w);
    end
    tests++;
    if (obs_idx.size() != exp_idx.size()) begin
      fails++;
      $display("FAIL %s nwrites: got %0d required %0d", nm, obs_idx.size(), exp_idx.size());
    end
    for (int k = 0; k < exp_idx.size() && k < obs_idx.size(); k++) begin
      tests++;
      if (obs_idx[k] !== exp_idx[k] || obs_ent[k] !== exp_ent[k]) begin
        fails++;
        $display("FAIL %s write%0d: got (%h,%h) required (%h,%h)", nm, k,
                 obs_idx[k], obs_ent[k], exp_idx[k], exp_ent[k]);
      end
    end
    tests++;
    if (done_cnt != int'(exp_done) || err_cnt != int'(exp_err)) begin
      fails++;
      $display("FAIL %s status: done=%0d err=%0d required done=%0d err=%0d", nm,
               done_cnt, err_cnt, exp_done, exp_err);
    end
    tests++;
    if (req_hs_cyc.size() != nb) begin
      fails++;
      $display("FAIL %s beats_taken: got %0d required %0d", nm, req_hs_cyc.size(), nb);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({mtt_req_ready, mtt_wr_valid, cmd_done, cmd_err} !== 4'b0 ||
        mtt_wr_index !== 64'd0 || mtt_wr_entry !== 64'd0) begin
      fails++;
      $display("FAIL reset_outputs: rdy=%b wv=%b done=%b err=%b idx=%h ent=%h required all 0",
               mtt_req_ready, mtt_wr_valid, cmd_done, cmd_err, mtt_wr_index, mtt_wr_entry);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (mtt_req_ready !== 1'b1 || mtt_wr_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: rdy=%b wv=%b required 1 0", mtt_req_ready, mtt_wr_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_partial_beat();
    run_cmd("partial", CMD_WR_MTT_TPT, 16'd3, 64'h100, 1, 0);
  endtask

  task automatic test_two_beats();
    run_cmd("two_beats", CMD_WR_MTT_TPT, 16'd6, 64'h1FE, 2, 0);
    tests++;
    if (obs_cyc.size() != 6 || req_hs_cyc.size() != 2) begin
      fails++;
      $display("FAIL two_beats timing_data: writes=%0d beats=%0d required 6 2",
               obs_cyc.size(), req_hs_cyc.size());
    end else begin
      if (obs_cyc[0] - req_hs_cyc[0] != 1 || obs_cyc[3] - obs_cyc[0] != 3 ||
          obs_cyc[4] - obs_cyc[3] != 2) begin
        fails++;
        $display("FAIL two_beats timing: lat=%0d run=%0d gap=%0d required 1 3 2",
                 obs_cyc[0] - req_hs_cyc[0], obs_cyc[3] - obs_cyc[0], obs_cyc[4] - obs_cyc[3]);
      end
    end
  endtask

  task automatic test_short_data();
    run_cmd("short", CMD_WR_MTT_TPT, 16'd5, $urandom, 1, 0);
    tests++;
    if (pulse_ready !== 1'b1) begin
      fails++;
      $display("FAIL short ready_after_err: got %b required 1", pulse_ready);
    end
    run_cmd("after_short", CMD_WR_MTT_TPT, 16'd4, $urandom, 1, 0);
  endtask

  task automatic test_excess_beats();
    run_cmd("excess", CMD_WR_MTT_TPT, 16'd2, $urandom, 3, 1);
  endtask

  task automatic test_bad_format();
    run_cmd("bad_type", CMD_WR_MPT, 16'd4, $urandom, 2, 0);
    run_cmd("zero_count", CMD_WR_MTT_TPT, 16'd0, $urandom, 1, 0);
  endtask

  task automatic test_reset_mid_issue();
    int w;
    beats.delete();
    beats.push_back({$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom});
    stall_mode = 2;
    done_cnt = 0; err_cnt = 0;
    mtt_req_valid = 1'b1;
    mtt_req_head  = {CMD_WR_MTT_TPT, 44'h0, 16'd2, 64'hFFFF_FFFF_FFFF_FFFF};
    mtt_req_data  = beats[0];
    mtt_req_last  = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (!mtt_req_ready && w < 100);
    @(posedge clk); #1;
    mtt_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (mtt_wr_valid !== 1'b1 || mtt_wr_index !== 64'hFFFF_FFFF_FFFF_FFFF ||
        mtt_wr_entry !== beats[0][63:0]) begin
      fails++;
      $display("FAIL held_issue: wv=%b idx=%h ent=%h required 1 ffffffffffffffff %h",
               mtt_wr_valid, mtt_wr_index, mtt_wr_entry, beats[0][63:0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({mtt_req_ready, mtt_wr_valid, cmd_done, cmd_err} !== 4'b0 || mtt_wr_index !== 64'd0) begin
      fails++;
      $display("FAIL reset_mid_issue: rdy=%b wv=%b done=%b err=%b idx=%h required all 0",
               mtt_req_ready, mtt_wr_valid, cmd_done, cmd_err, mtt_wr_index);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    stall_mode = 1;
    repeat (4) @(negedge clk);
    tests++;
    if (mtt_req_ready !== 1'b1 || mtt_wr_valid !== 1'b0 || done_cnt != 0 || err_cnt != 0) begin
      fails++;
      $display("FAIL clean_idle: rdy=%b wv=%b done=%0d err=%0d required 1 0 0 0",
               mtt_req_ready, mtt_wr_valid, done_cnt, err_cnt);
    end
    @(posedge clk); #1;
    run_cmd("wrap", CMD_WR_MTT_TPT, 16'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [3:0] typ;
      typ = ($urandom_range(0, 5) == 0) ? CMD_DEREG_MR : CMD_WR_MTT_TPT;
      stall_mode = $urandom_range(0, 1);
      run_cmd($sformatf("rand%0d", i), typ, 16'($urandom_range(0, 13)),
              {$urandom, $urandom}, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end
    stall_mode = 0;
  endtask

  initial begin
    test_reset();
    test_partial_beat();
    test_two_beats();
    test_short_data();
    test_excess_beats();
    test_bad_format();
    test_reset_mid_issue();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
